pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register, successor to the fixed always-enabled inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload plus a control field through a valid/ready handshake.
- Supports back-pressure (stall) and synchronous flush (bubble insertion that zeroes control).
- Optional 2-entry skid buffer breaks the combinational ready path for timing.

Parameters:
DATA_W, 32, width of data payload (operands, PC, immediates, rd address; packed by instantiating stage).
CTRL_W, 8, width of control field (reg_write, mem_write, branch, jump, ...); forced to 0 whenever the stage holds a bubble.
SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_valid  input  1  upstream stage presents a valid instruction.
o_ready  output  1  this stage can accept; transfer in = i_valid & o_ready.
i_data  input  DATA_W  upstream payload.
i_ctrl  input  CTRL_W  upstream control bits.
i_flush  input  1  synchronous kill of all held and incoming entries (branch mispredict/jump).
o_valid  output  1  downstream entry valid.
i_ready  input  1  downstream can accept; transfer out = o_valid & i_ready.
o_data  output  DATA_W  head payload.
o_ctrl  output  CTRL_W  head control; 0 whenever o_valid=0.
o_occupancy  output  2  entries held: 0, 1, or 2 (2 only when SKID=1).

Behaviour:
- Reset (async assert, released sync to i_clk): o_valid=0, o_data=0, o_ctrl=0, skid entry cleared, o_occupancy=0. o_ready=1 from the first cycle after release.
- Latency: 1 cycle. Data accepted at edge N appears on o_data after edge N. All outputs are registered except o_ready when SKID=0.
- SKID=0:
  - o_ready = ~o_valid | i_ready.
  - On in-transfer, main register loads i_data/i_ctrl and o_valid=1.
  - On out-transfer without in-transfer, o_valid=0 and ctrl cleared.
- SKID=1 states (main entry M, skid entry S):
  - EMPTY (occ 0): in-transfer -> ONE, M<=input.
  - ONE (occ 1):
    - in & out -> ONE, M<=input.
    - in & ~i_ready -> TWO, S<=input.
    - out & ~in -> EMPTY.
    - neither -> hold.
  - TWO (occ 2): o_ready=0. Out-transfer -> ONE, M<=S, S cleared. Otherwise hold.
  - o_ready = (occupancy != 2), from registered state only.
- Ordering: strict FIFO. S is always younger than M.
- Stall (i_ready=0): held entries, o_data and o_ctrl are stable, with no glitches or reloads.
- Flush:
  - i_flush=1 at edge N: after N, occupancy=0, o_valid=0, o_ctrl=0, S invalidated.
  - Any in-transfer at edge N is discarded.
  - An out-transfer at edge N still completes downstream; the downstream stage owns its own flush.
  - o_data is don't-care after flush; implementation may hold old data.
  - Flush has priority over every other event in the same cycle.
- Bubble rule: whenever an entry is invalid, its ctrl bits are 0, so reg_write and mem_write can never leak from a bubble.
- Reset mid-operation: asynchronous clear regardless of state, including TWO with stall.
- i_data/i_ctrl are ignored when i_valid=0 or o_ready=0.

Test Plan:
- Streaming, SKID=1, i_ready=1: 4 back-to-back inputs 0x11,0x22,0x33,0x44 with ctrl=0x81 -> same sequence on o_data one cycle later, o_valid continuous, o_occupancy=1, o_ready=1 throughout.
- Back-pressure, SKID=1: send 0xA,0xB,0xC; drop i_ready after 0xA appears, hold 3 cycles -> o_data stays 0xA, occupancy reaches 2, o_ready=0, 0xC held off upstream. Release i_ready -> 0xA,0xB,0xC in order with no loss or duplication.
- Flush in TWO state: occupancy=2 with ctrl=0xFF, assert i_flush one cycle while i_valid=1 (0xD) -> next cycle o_valid=0, o_ctrl=0x00, occupancy=0, 0xD never appears on output.
- SKID=0 combinational ready: o_valid=1, i_ready=0 -> o_ready=0 same cycle; raise i_ready -> o_ready=1 same cycle, simultaneous in/out keeps occupancy=1 with new data.
- Async reset mid-stall: occupancy=2, assert i_rst_n=0 between clock edges -> o_valid, o_ctrl, o_data, o_occupancy go to 0 immediately. After release, o_ready=1 and the first accepted input (0x55) emerges one cycle later.
- Random regression: 10k cycles of random i_valid/i_ready/i_flush (flush 2%) against a scoreboard queue -> FIFO order preserved, no output while o_valid=0 with nonzero o_ctrl, occupancy matches model, both SKID values.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one pipeline payload plus its control field.
// The stage uses the slave side toward the upstream stage and the master side toward the downstream stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and an optional skid entry.
// Bubbles always carry zero control, so no write-enable can leak downstream from an invalid slot.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_flush,
  output logic [1:0]     o_occupancy,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] m_data_reg, m_data_next;
  logic [CTRL_W-1:0] m_ctrl_reg, m_ctrl_next;
  logic [DATA_W-1:0] s_data_reg, s_data_next;
  logic [CTRL_W-1:0] s_ctrl_reg, s_ctrl_next;
  logic              in_xfer;
  logic              out_xfer;

  // With the skid entry, ready depends only on registered state; without it, it passes i_ready through.
  generate
    if (SKID != 0) begin : g_skid
      assign up.ready = (state_reg != TWO);
    end else begin : g_no_skid
      assign up.ready = ~valid_reg | dn.ready;
    end
  endgenerate

  assign in_xfer  = up.valid & up.ready;
  assign out_xfer = valid_reg & dn.ready;

  always_comb begin
    state_next  = state_reg;
    m_data_next = m_data_reg;
    m_ctrl_next = m_ctrl_reg;
    s_data_next = s_data_reg;
    s_ctrl_next = s_ctrl_reg;
    if (i_flush) begin
      // Data may stay stale; clearing control is what turns the slots into bubbles.
      state_next  = EMPTY;
      m_ctrl_next = '0;
      s_ctrl_next = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next  = ONE;
            m_data_next = up.data;
            m_ctrl_next = up.ctrl;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_data_next = up.data;
            m_ctrl_next = up.ctrl;
          end else if (in_xfer) begin
            state_next  = TWO;
            s_data_next = up.data;
            s_ctrl_next = up.ctrl;
          end else if (out_xfer) begin
            state_next  = EMPTY;
            m_ctrl_next = '0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_next  = ONE;
            m_data_next = s_data_reg;
            m_ctrl_next = s_ctrl_reg;
            s_data_next = '0;
            s_ctrl_next = '0;
          end
        end
        default: begin
          state_next  = EMPTY;
          m_ctrl_next = '0;
          s_ctrl_next = '0;
        end
      endcase
    end
    valid_next = (state_next != EMPTY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= EMPTY;
      valid_reg  <= 1'b0;
      m_data_reg <= '0;
      m_ctrl_reg <= '0;
      s_data_reg <= '0;
      s_ctrl_reg <= '0;
    end else begin
      state_reg  <= state_next;
      valid_reg  <= valid_next;
      m_data_reg <= m_data_next;
      m_ctrl_reg <= m_ctrl_next;
      s_data_reg <= s_data_next;
      s_ctrl_reg <= s_ctrl_next;
    end
  end

  assign dn.valid    = valid_reg;
  assign dn.data     = m_data_reg;
  assign dn.ctrl     = m_ctrl_reg;
  assign o_occupancy = state_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid and a non-skid stage with shared stimulus and checks both against queue-based models.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occ1;
  logic [1:0] occ0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn0 ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .o_occupancy(occ1), .up(up1), .dn(dn1)
  );
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_no_skid (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .o_occupancy(occ0), .up(up0), .dn(dn0)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  // Model entries are {ctrl, data}; the front of each queue is what the stage must present.
  logic [39:0] q1[$];
  logic [39:0] q0[$];
  logic [39:0] log1[$];

  logic        drv_valid;
  logic [31:0] drv_data;
  logic [7:0]  drv_ctrl;
  logic        drv_flush;
  logic        drv_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic f, input logic r);
    drv_valid = v; drv_data = d; drv_ctrl = c; drv_flush = f; drv_ready = r;
    up1.valid = v; up1.data = d; up1.ctrl = c; dn1.ready = r;
    up0.valid = v; up0.data = d; up0.ctrl = c; dn0.ready = r;
    flush = f;
  endtask

  task automatic check_outputs();
    check("valid_s1", 64'(dn1.valid), 64'(q1.size() != 0));
    check("occ_s1", 64'(occ1), 64'(q1.size()));
    if (q1.size() != 0) begin
      check("data_s1", 64'(dn1.data), 64'(q1[0][31:0]));
      check("ctrl_s1", 64'(dn1.ctrl), 64'(q1[0][39:32]));
    end else begin
      check("bubble_ctrl_s1", 64'(dn1.ctrl), 64'd0);
    end
    check("valid_s0", 64'(dn0.valid), 64'(q0.size() != 0));
    check("occ_s0", 64'(occ0), 64'(q0.size()));
    if (q0.size() != 0) begin
      check("data_s0", 64'(dn0.data), 64'(q0[0][31:0]));
      check("ctrl_s0", 64'(dn0.ctrl), 64'(q0[0][39:32]));
    end else begin
      check("bubble_ctrl_s0", 64'(dn0.ctrl), 64'd0);
    end
  endtask

  // One clock: check ready mid-cycle, apply the edge to the models, check outputs just after.
  task automatic cycle();
    bit rdy1, rdy0, in1, in0, out1, out0;
    logic [39:0] item;
    @(negedge clk);
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || drv_ready;
    check("ready_s1", 64'(up1.ready), 64'(rdy1));
    check("ready_s0", 64'(up0.ready), 64'(rdy0));
    item = {drv_ctrl, drv_data};
    in1  = drv_valid && rdy1;
    in0  = drv_valid && rdy0;
    out1 = (q1.size() != 0) && drv_ready;
    out0 = (q0.size() != 0) && drv_ready;
    @(posedge clk);
    if (out1) begin
      log1.push_back(q1[0]);
      if (verbose) $display("[%0t] skid1 out data=0x%0h ctrl=0x%0h", $time, q1[0][31:0], q1[0][39:32]);
    end
    if (out0 && verbose)
      $display("[%0t] skid0 out data=0x%0h ctrl=0x%0h", $time, q0[0][31:0], q0[0][39:32]);
    if (drv_flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out1) void'(q1.pop_front());
      if (in1) q1.push_back(item);
      if (out0) void'(q0.pop_front());
      if (in0) q0.push_back(item);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] stream_vals[4];
    logic [31:0] bp_vals[3];
    stream_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    bp_vals     = '{32'hA, 32'hB, 32'hC};
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid_s1", 64'(dn1.valid), 64'd0);
    check("rst_data_s1", 64'(dn1.data), 64'd0);
    check("rst_ctrl_s1", 64'(dn1.ctrl), 64'd0);
    check("rst_occ_s1", 64'(occ1), 64'd0);
    check("rst_valid_s0", 64'(dn0.valid), 64'd0);
    check("rst_occ_s0", 64'(occ0), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_s1", 64'(up1.ready), 64'd1);
    check("rel_ready_s0", 64'(up0.ready), 64'd1);

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_vals[i], 8'h81, 1'b0, 1'b1);
      cycle();
      check("stream_data", 64'(dn1.data), 64'(stream_vals[i]));
      check("stream_occ", 64'(occ1), 64'd1);
    end
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    cycle();

    // Back-pressure fills the skid entry, then drains in order
    log1.delete();
    drive(1'b1, 32'hA, 8'h21, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'hB, 8'h22, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC, 8'h23, 1'b0, 1'b0);
      cycle();
      check("bp_hold_data", 64'(dn1.data), 64'hA);
      check("bp_occ", 64'(occ1), 64'd2);
      check("bp_ready", 64'(up1.ready), 64'd0);
    end
    drive(1'b1, 32'hC, 8'h23, 1'b0, 1'b1);
    cycle();
    cycle();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    cycle();
    check("bp_count", 64'(log1.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < log1.size()) check("bp_order", 64'(log1[i][31:0]), 64'(bp_vals[i]));

    // Flush while two entries are held and a new input is offered
    drive(1'b1, 32'h1, 8'hFF, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h2, 8'hFF, 1'b0, 1'b0);
    cycle();
    check("pre_flush_occ", 64'(occ1), 64'd2);
    drive(1'b1, 32'hD, 8'hFF, 1'b1, 1'b0);
    cycle();
    check("flush_valid", 64'(dn1.valid), 64'd0);
    check("flush_ctrl", 64'(dn1.ctrl), 64'd0);
    check("flush_occ", 64'(occ1), 64'd0);
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    cycle();
    cycle();

    // Combinational ready without the skid entry
    drive(1'b1, 32'h61, 8'h03, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h61, 8'h03, 1'b0, 1'b0);
    #1;
    check("noskid_ready_stall", 64'(up0.ready), 64'd0);
    drive(1'b0, 32'h61, 8'h03, 1'b0, 1'b1);
    #1;
    check("noskid_ready_go", 64'(up0.ready), 64'd1);
    drive(1'b1, 32'h62, 8'h03, 1'b0, 1'b1);
    cycle();
    check("noskid_occ", 64'(occ0), 64'd1);
    check("noskid_data", 64'(dn0.data), 64'h62);
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    cycle();

    // Asynchronous reset while stalled with two entries
    drive(1'b1, 32'h71, 8'h0F, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h72, 8'h0F, 1'b0, 1'b0);
    cycle();
    check("prerst_occ", 64'(occ1), 64'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid_s1", 64'(dn1.valid), 64'd0);
    check("arst_ctrl_s1", 64'(dn1.ctrl), 64'd0);
    check("arst_data_s1", 64'(dn1.data), 64'd0);
    check("arst_occ_s1", 64'(occ1), 64'd0);
    check("arst_valid_s0", 64'(dn0.valid), 64'd0);
    check("arst_ctrl_s0", 64'(dn0.ctrl), 64'd0);
    check("arst_data_s0", 64'(dn0.data), 64'd0);
    check("arst_occ_s0", 64'(occ0), 64'd0);
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 8'h0F, 1'b0, 1'b1);
    #1;
    check("arst_ready_s1", 64'(up1.ready), 64'd1);
    check("arst_ready_s0", 64'(up0.ready), 64'd1);
    cycle();
    check("post_rst_valid", 64'(dn1.valid), 64'd1);
    check("post_rst_data_s1", 64'(dn1.data), 64'h55);
    check("post_rst_data_s0", 64'(dn0.data), 64'h55);
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    cycle();

    // Random regression
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 4) != 0, $urandom, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 2, ($urandom % 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
